mem_arbiter: RTL

Two-port arbiter that shares the SOC's single-port word RAM between the core's instruction-fetch port and its load/store data port. It replaces direct `MEM[PC[31:2]]` indexing in the core. It grants at most one access per cycle using round-robin or fixed priority, registers the RAM command, and routes each read response back to the port that issued it. Up to two transactions can be in flight.

---
 rtl/mem_arbiter_pkg.sv | 13 +
 rtl/mem_arbiter_rr_arb2.sv | 46 ++++
 rtl/mem_arbiter.sv | 91 +++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the instruction/data RAM arbiter: owner encoding,
// default address width and the read write-mask encoding.
package mem_arbiter_pkg;

    typedef enum logic {
        OWNER_I = 1'b0,
        OWNER_D = 1'b1
    } owner_e;

    localparam int         ADDR_W_DEF = 8;
    localparam logic [3:0] WMASK_READ = 4'b0000;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way grant logic for the RAM arbiter: round-robin on ties, optionally
// overridden so the data port always wins, plus the last-owner pointer.
module rr_arb2
    import mem_arbiter_pkg::*;
#(
    parameter int FIXED_PRIO = 0
) (
    input  logic clk,
    input  logic resetn,
    input  logic i_req,
    input  logic d_req,
    output logic i_gnt,
    output logic d_gnt
);

    owner_e last_owner;

    // Grants are forced low while reset is held, independent of the requests.
    always_comb begin
        i_gnt = 1'b0;
        d_gnt = 1'b0;
        if (resetn) begin
            if (i_req && d_req) begin
                if ((FIXED_PRIO != 0) || (last_owner == OWNER_I)) begin
                    d_gnt = 1'b1;
                end else begin
                    i_gnt = 1'b1;
                end
            end else begin
                i_gnt = i_req;
                d_gnt = d_req;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last_owner <= OWNER_D;
        end else if (i_gnt) begin
            last_owner <= OWNER_I;
        end else if (d_gnt) begin
            last_owner <= OWNER_D;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port word RAM between instruction fetch and load/store:
// combinational grant, registered RAM command, in-order response routing.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int FIXED_PRIO = 0
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [31:0]       i_rdata,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [3:0]        d_wmask,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_wmask,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    logic   vld_p0;
    owner_e own_p0;
    logic   vld_p1;
    owner_e own_p1;
    logic   vld_p2;
    owner_e own_p2;

    rr_arb2 #(
        .FIXED_PRIO(FIXED_PRIO)
    ) u_arb (
        .clk   (clk),
        .resetn(resetn),
        .i_req (i_req),
        .d_req (d_req),
        .i_gnt (i_gnt),
        .d_gnt (d_gnt)
    );

    assign vld_p0 = i_gnt | d_gnt;
    assign own_p0 = d_gnt ? OWNER_D : OWNER_I;

    // Stage p0 -> p1: register the granted command onto the RAM port.
    // Address/mask/data hold their previous values when nothing is granted.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_en    <= 1'b0;
            mem_addr  <= '0;
            mem_wmask <= WMASK_READ;
            mem_wdata <= '0;
            vld_p1    <= 1'b0;
            own_p1    <= OWNER_I;
        end else begin
            mem_en <= vld_p0;
            vld_p1 <= vld_p0;
            own_p1 <= own_p0;
            if (vld_p0) begin
                mem_addr  <= d_gnt ? d_addr : i_addr;
                mem_wmask <= d_gnt ? d_wmask : WMASK_READ;
            end
            if (d_gnt) begin
                mem_wdata <= d_wdata;
            end
        end
    end

    // Stage p1 -> p2: RAM data is valid now; writes acknowledge in the same slot.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vld_p2 <= 1'b0;
            own_p2 <= OWNER_I;
        end else begin
            vld_p2 <= vld_p1;
            own_p2 <= own_p1;
        end
    end

    assign i_rvalid = vld_p2 && (own_p2 == OWNER_I);
    assign d_rvalid = vld_p2 && (own_p2 == OWNER_D);
    assign i_rdata  = mem_rdata;
    assign d_rdata  = mem_rdata;

endmodule
